serial_add_ctrl: RTL

Bit-serial add/subtract sequencer for the 10-bit computer datapath. It time-shares one instance of the team's 1-bit `full_adder` cell across all operand bits, LSB first, one bit per clock. It presents a start/busy/done handshake to the control unit and returns a registered result with carry, overflow and zero flags. It replaces a WIDTH-cell ripple adder where area matters more than latency.

---
 rtl/serial_add_pkg.sv | 16 +
 rtl/serial_add_ctrl_full_adder.sv | 14 +
 rtl/serial_add_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
// Holds the FSM state encoding, the op encoding and the default datapath width.
package serial_add_pkg;

  localparam int DATA_W = 10;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full adder cell, time-shared by the serial sequencer across all
// operand bits.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full_adder cell processes operands
// LSB first, one bit per clock, behind a start/busy/done handshake.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shifted;
  logic             c;
  logic [CNT_W-1:0] cnt;

  logic fa_sum;
  logic fa_cout;
  logic last_bit;
  logic cin_msb;
  logic finish;

  full_adder u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (c),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit   = (cnt == LAST_BIT);
  assign sr_shifted = {fa_sum, sr[WIDTH-1:1]};
  // Carry into the MSB is the carry register's value while the last bit is computed.
  assign cin_msb    = c;
  assign finish     = (state == RUN) && last_bit;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // NOTE: the operand shift registers are reset too, so an interrupted
  // operation leaves no stale bits behind after rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      sr  <= '0;
      c   <= 1'b0;
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            // Subtract is a + ~b + 1: invert at load, the +1 enters as the initial carry.
            sb  <= (op == OP_SUB) ? ~b : b;
            c   <= op;
            cnt <= '0;
            sr  <= '0;
          end
        end
        RUN: begin
          sr  <= sr_shifted;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          c   <= fa_cout;
          cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result and flags only move on the edge that completes the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (finish) begin
      result   <= sr_shifted;
      carry    <= fa_cout;
      overflow <= cin_msb ^ fa_cout;
      zero     <= (sr_shifted == '0);
    end
  end

endmodule
